// File: rtl/soma_csr_pkg.sv
// Shared constants for the SOMA CSR controller: register indices, CTRL/STATUS
// bit positions, run-state encoding and the accelerator UUID.
package soma_csr_pkg;

  localparam int CSR_IDX_W = 8;
  typedef logic [CSR_IDX_W-1:0] csr_idx_t;

  localparam csr_idx_t CSR_SCRATCH   = 8'h02;
  localparam csr_idx_t CSR_CTRL      = 8'h03;
  localparam csr_idx_t CSR_STATUS    = 8'h04;
  localparam csr_idx_t CSR_CYCLES    = 8'h05;
  localparam csr_idx_t CSR_TIMEOUT   = 8'h06;
  localparam csr_idx_t CSR_CAP       = 8'h07;
  localparam csr_idx_t CSR_SVC_MASK  = 8'h08;
  localparam csr_idx_t CSR_FIN_SEEN  = 8'h09;
  localparam csr_idx_t CSR_STAT_BASE = 8'h0A;
  localparam csr_idx_t CSR_ADDR_BASE = 8'h10;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int STS_BUSY    = 0;
  localparam int STS_DONE    = 1;
  localparam int STS_ABORTED = 2;
  localparam int STS_TIMEOUT = 3;

  localparam logic [127:0] AFU_ACCEL_UUID = 128'h5f3c9a1e_47b2_4d0c_9e81_3a6bd2f0c715;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_e;

endpackage

// File: rtl/app_csrs.sv
// Host-to-accelerator CSR bus: single-cycle write strobe and a combinational
// read port indexed by rd_idx.
interface app_csrs;
  import soma_csr_pkg::*;

  logic         wr_en;
  csr_idx_t     wr_idx;
  logic [63:0]  wr_data;
  csr_idx_t     rd_idx;
  logic [63:0]  rd_data;
  logic [127:0] afu_id;

  modport app (
    input  wr_en, wr_idx, wr_data, rd_idx,
    output rd_data, afu_id
  );
endinterface

// File: rtl/soma_run_fsm.sv
// Run control: IDLE/RUN/DONE sequencing, sticky finish tracking, cycle
// counting and timeout detection for one batch of services.
module soma_run_fsm
  import soma_csr_pkg::*;
#(
  parameter int NUM_SVC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic               cmd_clear,
  input  logic [NUM_SVC-1:0] svc_mask,
  input  logic [63:0]        timeout_val,
  input  logic [NUM_SVC-1:0] svc_finish,
  output logic               busy,
  output logic [NUM_SVC-1:0] svc_start,
  output logic               svc_abort,
  output logic [3:0]         status,
  output logic [63:0]        cycles,
  output logic [NUM_SVC-1:0] fin_seen
);

  run_state_e         state, state_nxt;
  logic               aborted, aborted_nxt;
  logic               timed_out, timed_out_nxt;
  logic [NUM_SVC-1:0] fin_nxt, start_nxt;
  logic [63:0]        cycles_nxt;
  logic               abort_nxt;

  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

  always_comb begin
    state_nxt     = state;
    aborted_nxt   = aborted;
    timed_out_nxt = timed_out;
    fin_nxt       = fin_seen;
    cycles_nxt    = cycles;
    start_nxt     = '0;
    abort_nxt     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (cmd_start) begin
          state_nxt     = ST_RUN;
          aborted_nxt   = 1'b0;
          timed_out_nxt = 1'b0;
          fin_nxt       = '0;
          cycles_nxt    = '0;
          start_nxt     = svc_mask;
        end else if (cmd_clear && state == ST_DONE) begin
          state_nxt     = ST_IDLE;
          aborted_nxt   = 1'b0;
          timed_out_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        // The finish arriving this cycle counts, so completion beats a
        // simultaneous abort or timeout.
        fin_nxt    = fin_seen | (svc_finish & svc_mask);
        cycles_nxt = sat_inc(cycles);
        if (fin_nxt == svc_mask) begin
          state_nxt = ST_DONE;
        end else if (cmd_abort) begin
          state_nxt   = ST_DONE;
          aborted_nxt = 1'b1;
          abort_nxt   = 1'b1;
        end else if (timeout_val != 64'd0 && cycles_nxt >= timeout_val) begin
          state_nxt     = ST_DONE;
          timed_out_nxt = 1'b1;
          abort_nxt     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      aborted   <= 1'b0;
      timed_out <= 1'b0;
      fin_seen  <= '0;
      cycles    <= '0;
      svc_start <= '0;
      svc_abort <= 1'b0;
    end else begin
      state     <= state_nxt;
      aborted   <= aborted_nxt;
      timed_out <= timed_out_nxt;
      fin_seen  <= fin_nxt;
      cycles    <= cycles_nxt;
      svc_start <= start_nxt;
      svc_abort <= abort_nxt;
    end
  end

  assign busy = (state == ST_RUN);

  always_comb begin
    status              = '0;
    status[STS_BUSY]    = (state == ST_RUN);
    status[STS_DONE]    = (state == ST_DONE);
    status[STS_ABORTED] = aborted;
    status[STS_TIMEOUT] = timed_out;
  end

endmodule

// File: rtl/soma_csr_ctrl.sv
// CSR block for the SOMA accelerator: register file, CTRL decode, address
// translation to cache lines, and the read mux around the run controller.
module soma_csr_ctrl
  import soma_csr_pkg::*;
#(
  parameter int          NUM_SVC  = 2,
  parameter int          NUM_ADDR = 6,
  parameter int          NUM_STAT = 1,
  parameter logic [63:0] CAP_RST  = 64'd16384
) (
  input  logic                         clk,
  input  logic                         SoftReset,
  app_csrs.app                         csrs,
  output logic [NUM_SVC-1:0]           svc_start,
  output logic                         svc_abort,
  input  logic [NUM_SVC-1:0]           svc_finish,
  input  logic [NUM_STAT-1:0][63:0]    stat_in,
  output logic [NUM_ADDR-1:0][63:0]    cl_addr,
  output logic [31:0]                  capacity
);

  logic [63:0]               scratch, timeout_r, cap_r;
  logic [NUM_SVC-1:0]        svc_mask_r, fin_seen;
  logic [NUM_ADDR-1:0][63:0] addr_r;
  logic [63:0]               cycles;
  logic [3:0]                status;
  logic                      run_busy;
  logic                      wr_ctrl, cmd_start, cmd_abort, cmd_clear;
  logic [63:0]               rd_data;

  // One command per CTRL write: abort outranks start, start outranks clear.
  assign wr_ctrl   = csrs.wr_en && (csrs.wr_idx == CSR_CTRL);
  assign cmd_abort = wr_ctrl && csrs.wr_data[CTRL_ABORT];
  assign cmd_start = wr_ctrl && csrs.wr_data[CTRL_START] && !csrs.wr_data[CTRL_ABORT];
  assign cmd_clear = wr_ctrl && csrs.wr_data[CTRL_CLEAR] && !csrs.wr_data[CTRL_ABORT]
                     && !csrs.wr_data[CTRL_START];

  soma_run_fsm #(.NUM_SVC(NUM_SVC)) u_run (
    .clk         (clk),
    .rst         (SoftReset),
    .cmd_start   (cmd_start),
    .cmd_abort   (cmd_abort),
    .cmd_clear   (cmd_clear),
    .svc_mask    (svc_mask_r),
    .timeout_val (timeout_r),
    .svc_finish  (svc_finish),
    .busy        (run_busy),
    .svc_start   (svc_start),
    .svc_abort   (svc_abort),
    .status      (status),
    .cycles      (cycles),
    .fin_seen    (fin_seen)
  );

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      scratch    <= '0;
      timeout_r  <= '0;
      cap_r      <= CAP_RST;
      svc_mask_r <= '1;
      addr_r     <= '0;
      cl_addr    <= '0;
    end else begin
      if (csrs.wr_en) begin
        if (csrs.wr_idx == CSR_SCRATCH) scratch <= csrs.wr_data;
        // Run configuration is frozen while services are executing.
        if (!run_busy) begin
          if (csrs.wr_idx == CSR_TIMEOUT)  timeout_r  <= csrs.wr_data;
          if (csrs.wr_idx == CSR_CAP)      cap_r      <= csrs.wr_data;
          if (csrs.wr_idx == CSR_SVC_MASK) svc_mask_r <= csrs.wr_data[NUM_SVC-1:0];
          for (int i = 0; i < NUM_ADDR; i++) begin
            if (csrs.wr_idx == CSR_ADDR_BASE + csr_idx_t'(i)) addr_r[i] <= csrs.wr_data;
          end
        end
      end
      for (int i = 0; i < NUM_ADDR; i++) begin
        cl_addr[i] <= {6'b0, addr_r[i][63:6]};
      end
    end
  end

  assign capacity = cap_r[31:0];

  always_comb begin
    rd_data = '0;
    case (csrs.rd_idx)
      CSR_SCRATCH:  rd_data = scratch;
      CSR_STATUS:   rd_data = {60'd0, status};
      CSR_CYCLES:   rd_data = cycles;
      CSR_TIMEOUT:  rd_data = timeout_r;
      CSR_CAP:      rd_data = cap_r;
      CSR_SVC_MASK: rd_data = 64'(svc_mask_r);
      CSR_FIN_SEEN: rd_data = 64'(fin_seen);
      default:      rd_data = '0;
    endcase
    for (int i = 0; i < NUM_STAT; i++) begin
      if (csrs.rd_idx == CSR_STAT_BASE + csr_idx_t'(i)) rd_data = stat_in[i];
    end
    for (int i = 0; i < NUM_ADDR; i++) begin
      if (csrs.rd_idx == CSR_ADDR_BASE + csr_idx_t'(i)) rd_data = addr_r[i];
    end
  end

  assign csrs.rd_data = rd_data;
  assign csrs.afu_id  = AFU_ACCEL_UUID;

endmodule
